// File: rtl/spi_result_transmitter.sv
// SPI mode-0 peripheral transmitter: returns controller-supplied bytes on CIPO,
// MSB first, with SCLK/CS oversampled in the clk domain.
module spi_result_transmitter #(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    output logic       CIPO,
    output logic       cipo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       underrun,
    input  logic       clear,
    output logic [7:0] byte_count
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       got_rise;

    logic load_en, shift_en, cnt_en, abort_set, go_idle, cs_start;

    // Synchronizers idle at SCLK low / CS deasserted so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tx_ready  = 1'b0;
        cipo_oe   = 1'b0;
        CIPO      = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        cnt_en    = 1'b0;
        abort_set = 1'b0;
        go_idle   = 1'b0;
        cs_start  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nx = LOAD;
                    cs_start = 1'b1;
                end
            end
            LOAD: begin
                cipo_oe = 1'b1;
                if (cs_rise) begin
                    state_nx = IDLE;
                    go_idle  = 1'b1;
                end else begin
                    tx_ready = 1'b1;
                    load_en  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                cipo_oe = 1'b1;
                CIPO    = shift_reg[7];
                if (cs_rise) begin
                    state_nx  = IDLE;
                    go_idle   = 1'b1;
                    abort_set = (bit_cnt != 3'd0);
                end else begin
                    cnt_en = sclk_rise;
                    // bit_cnt==0 without a prior rise is the mode-0 idle-low fall
                    if (sclk_fall) begin
                        if (bit_cnt != 3'd0)  shift_en = 1'b1;
                        else if (got_rise)    state_nx = LOAD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            got_rise   <= 1'b0;
            tx_done    <= 1'b0;
            tx_abort   <= 1'b0;
            underrun   <= 1'b0;
            byte_count <= 8'h00;
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= abort_set;
            if (load_en) begin
                shift_reg <= tx_valid ? tx_data : IDLE_BYTE;
                got_rise  <= 1'b0;
            end
            if (shift_en)
                shift_reg <= {shift_reg[6:0], 1'b0};
            if (cnt_en) begin
                bit_cnt  <= bit_cnt + 3'd1;
                got_rise <= 1'b1;
                if (bit_cnt == 3'd7) tx_done <= 1'b1;
            end
            if (go_idle) begin
                bit_cnt  <= 3'd0;
                got_rise <= 1'b0;
            end
            // A substitution in the same cycle as clear keeps the flag set
            if (load_en && !tx_valid) underrun <= 1'b1;
            else if (clear)           underrun <= 1'b0;
            if (clear || cs_start)
                byte_count <= 8'h00;
            else if (cnt_en && bit_cnt == 3'd7)
                byte_count <= byte_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_result_transmitter.sv
// Directed bench for spi_result_transmitter: a host model drives SCLK/CS at
// clk/12 and samples CIPO on each SCLK rise.
module tb_spi_result_transmitter;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, clear, tx_valid;
    logic [7:0] tx_data;
    logic       cipo, cipo_oe, tx_ready, tx_done, tx_abort, underrun;
    logic [7:0] byte_count;

    spi_result_transmitter dut (
        .clk(clk), .rst(rst), .SCLK(sclk), .spi_cs_n(cs_n),
        .CIPO(cipo), .cipo_oe(cipo_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_abort(tx_abort), .underrun(underrun),
        .clear(clear), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int rdy_cnt = 0, done_cnt = 0, abt_cnt = 0;
    logic [15:0] rx;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic [7:0] exp_rd;
        logic       exp_und;
    } vec_t;
    vec_t vt[5];

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (tx_ready) rdy_cnt++;
            if (tx_done)  done_cnt++;
            if (tx_abort) abt_cnt++;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Each bit: 6 clk low, rise (host samples CIPO), 6 clk high; ends with SCLK high
    task automatic bits(input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            tick(6);
            sclk = 1'b1;
            rx = {rx[14:0], cipo};
            tick(6);
        end
    endtask

    task automatic zero_cnts();
        rdy_cnt = 0; done_cnt = 0; abt_cnt = 0; rx = '0;
    endtask

    initial begin
        vt[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vt[2] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
        vt[3] = '{8'h81, 1'b1, 8'h81, 1'b0};
        vt[4] = '{8'h12, 1'b0, 8'hFF, 1'b1};

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; clear = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx = '0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_cipo", cipo, 0);
        check("rst_oe", cipo_oe, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_abort", tx_abort, 0);
        check("rst_underrun", underrun, 0);
        check("rst_byte_count", byte_count, 0);

        // Single-byte windows; tx_valid held, counts snapshotted before the last fall
        for (int v = 0; v < 5; v++) begin
            clear = 1'b1; tick(1); clear = 1'b0;
            zero_cnts();
            tx_data = vt[v].data; tx_valid = vt[v].valid;
            cs_n = 1'b0;
            bits(8);
            check($sformatf("v%0d_read", v), rx[7:0], vt[v].exp_rd);
            check($sformatf("v%0d_ready", v), rdy_cnt, 1);
            check($sformatf("v%0d_done", v), done_cnt, 1);
            check($sformatf("v%0d_byte_count", v), byte_count, 1);
            check($sformatf("v%0d_underrun", v), underrun, vt[v].exp_und);
            sclk = 1'b0; tick(6);
            cs_n = 1'b1; tick(6);
            check($sformatf("v%0d_oe_off", v), cipo_oe, 0);
            check($sformatf("v%0d_abort", v), abt_cnt, 0);
        end
        tx_valid = 1'b0;
        clear = 1'b1; tick(1); clear = 1'b0; tick(1);
        check("clear_underrun", underrun, 0);
        check("clear_byte_count", byte_count, 0);

        // Back-to-back 0x3C, 0xC3: second byte offered once the first LOAD is done
        zero_cnts();
        tx_data = 8'h3C; tx_valid = 1'b1;
        cs_n = 1'b0;
        tick(5);
        check("b2b_ready_first", rdy_cnt, 1);
        tx_data = 8'hC3;
        bits(16);
        check("b2b_read", rx, 16'h3CC3);
        check("b2b_ready", rdy_cnt, 2);
        check("b2b_done", done_cnt, 2);
        check("b2b_byte_count", byte_count, 2);
        check("b2b_underrun", underrun, 0);
        sclk = 1'b0; tick(6); cs_n = 1'b1; tick(6);

        // Abort after 3 rises of 0x81, then a clean 0x81
        zero_cnts();
        tx_data = 8'h81;
        cs_n = 1'b0;
        bits(3);
        sclk = 1'b0; tick(6); cs_n = 1'b1; tick(6);
        check("abort_pulse", abt_cnt, 1);
        check("abort_no_done", done_cnt, 0);
        check("abort_oe_off", cipo_oe, 0);
        check("abort_byte_count", byte_count, 0);
        zero_cnts();
        cs_n = 1'b0;
        bits(8);
        check("after_abort_read", rx[7:0], 8'h81);
        check("after_abort_done", done_cnt, 1);
        sclk = 1'b0; tick(6); cs_n = 1'b1; tick(6);

        // Reset mid-byte, then a full 0x5A transfer
        tx_data = 8'hC7;
        cs_n = 1'b0;
        bits(4);
        rst = 1'b1; tick(1);
        check("midrst_cipo", cipo, 0);
        check("midrst_oe", cipo_oe, 0);
        check("midrst_ready", tx_ready, 0);
        check("midrst_done", tx_done, 0);
        check("midrst_abort", tx_abort, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_byte_count", byte_count, 0);
        cs_n = 1'b1; sclk = 1'b0; tick(4);
        rst = 1'b0; tick(4);
        zero_cnts();
        tx_data = 8'h5A;
        cs_n = 1'b0;
        bits(8);
        check("postrst_read", rx[7:0], 8'h5A);
        check("postrst_byte_count", byte_count, 1);
        sclk = 1'b0; tick(6); cs_n = 1'b1; tick(6);

        // CS rises on the same clk as the 8th SCLK fall: no LOAD, no abort
        zero_cnts();
        tx_data = 8'h96;
        cs_n = 1'b0;
        bits(8);
        check("csfall8_read", rx[7:0], 8'h96);
        sclk = 1'b0; cs_n = 1'b1;
        tick(8);
        check("csfall8_ready", rdy_cnt, 1);
        check("csfall8_done", done_cnt, 1);
        check("csfall8_abort", abt_cnt, 0);
        check("csfall8_byte_count", byte_count, 1);
        check("csfall8_oe_off", cipo_oe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
